// File: rtl/ovl_win_unchange_checker.sv
// Window stability checker: flags test_expr changes between start_event and end_event; OVL_WIN_UNCHANGE_COVER_EN adds window-open coverage on fire[2].
// Latency: fire bits registered, one-cycle pulse after the sampling edge; no backpressure (pure observer).
module ovl_win_unchange_checker #(
    parameter int width = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start_event,
    input  logic [width-1:0] test_expr,
    input  logic             end_event,
    output logic [2:0]       fire
);

    localparam logic CLOSED = 1'b0;
    localparam logic OPEN   = 1'b1;

    logic             r_state;
    logic [width-1:0] r_ref_val;
    logic             r_fire_viol;
    logic             w_changed;

    assign w_changed = (test_expr != r_ref_val);

    // ref_val tracks the latest in-window sample so a single change reports once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= CLOSED;
            r_ref_val   <= '0;
            r_fire_viol <= 1'b0;
        end else begin
            r_fire_viol <= 1'b0;
            if (r_state == CLOSED) begin
                if (start_event) begin
                    r_state   <= OPEN;
                    r_ref_val <= test_expr;
                end
            end else begin
                r_fire_viol <= enable & w_changed;
                if (w_changed) begin
                    r_ref_val <= test_expr;
                end
                if (end_event) begin
                    r_state <= CLOSED;
                end
            end
        end
    end

    assign fire[0] = r_fire_viol;
    assign fire[1] = 1'b0;

`ifdef OVL_WIN_UNCHANGE_COVER_EN
    logic r_fire_cov;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fire_cov <= 1'b0;
        end else begin
            r_fire_cov <= enable & start_event & (r_state == CLOSED);
        end
    end

    assign fire[2] = r_fire_cov;
`else
    assign fire[2] = 1'b0;
`endif

endmodule

// File: tb/tb_ovl_win_unchange_checker.sv
// Bench for ovl_win_unchange_checker: directed vector table, async-reset sequence, then random stimulus against a reference model.
module tb_ovl_win_unchange_checker;

`ifdef OVL_WIN_UNCHANGE_COVER_EN
    localparam bit COV = 1'b1;
`else
    localparam bit COV = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       start_event = 1'b0;
    logic       end_event = 1'b0;
    logic [3:0] test_expr = 4'h0;
    logic [2:0] fire;

    int total = 0;
    int bad   = 0;

    // Reference model: in a window, ref_val always equals the previous edge's sample
    bit         m_open = 1'b0;
    logic [3:0] m_prev = 4'h0;
    logic [2:0] m_fire = 3'b000;

    ovl_win_unchange_checker #(.width(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .start_event (start_event),
        .test_expr   (test_expr),
        .end_event   (end_event),
        .fire        (fire)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       st;
        logic       ed;
        logic [3:0] tx;
        logic       exp_viol;
        logic       exp_cov;
    } vec_t;

    vec_t vecs[28];

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: fire=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit viol;
        bit cov;
        viol = 1'b0;
        cov  = 1'b0;
        if (reset) begin
            m_open = 1'b0;
        end else if (m_open) begin
            viol = enable && (test_expr != m_prev);
            if (end_event) m_open = 1'b0;
        end else if (start_event) begin
            m_open = 1'b1;
            cov    = enable && COV;
        end
        m_prev = test_expr;
        m_fire = {cov, 1'b0, viol};
    endtask

    task automatic drive(input logic r, input logic e, input logic s, input logic d, input logic [3:0] t);
        @(negedge clock);
        reset       = r;
        enable      = e;
        start_event = s;
        end_event   = d;
        test_expr   = t;
        @(posedge clock);
        #1;
        model_edge();
    endtask

    initial begin
        //            rst  en   st   ed   tx       viol cov
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b0};
        vecs[25] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0};
        vecs[26] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};

        #1;
        check("reset_initial", fire, 3'b000);

        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].st, vecs[i].ed, vecs[i].tx);
            check($sformatf("vec%0d", i), fire, {vecs[i].exp_cov & COV, 1'b0, vecs[i].exp_viol});
        end

        // Asynchronous reset must clear a pending violation pulse without waiting for an edge
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0101);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
        check("viol_before_async_rst", fire, 3'b001);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_clears", fire, 3'b000);
        m_open = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("closed_after_async_rst", fire, 3'b000);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  4'($urandom_range(0, 2)));
            check($sformatf("rand%0d", i), fire, m_fire);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ovl_win_unchange_checker.md
# ovl_win_unchange_checker

Synchronous window-based stability checker (`ovl_win_unchange` in the codebase's OVL library). It opens a window on `start_event`, captures `test_expr`, and flags any change of `test_expr` until `end_event` closes the window. It is instantiated alongside the design it observes and drives a registered `fire` vector read by the verification environment. The stimulus clock comes from the separate bench utility `ivl_uvm_ovl_clk_gen`, which is not part of this block.

## Interface

- `width`, default 1: bit width of `test_expr`; legal range 1..1024.
- `clock` input 1: sampling clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high; it clears all state immediately.
- `enable` input 1: checking enable; 0 suppresses `fire[0]` and `fire[2]`.
- `start_event` input 1: window-open request.
- `test_expr` input `width`: value that must stay unchanged inside the window.
- `end_event` input 1: window-close request.
- `fire` output 3:
  - `fire[0]`: assertion violation.
  - `fire[1]`: X-check; tied 0.
  - `fire[2]`: coverage, window opened.

## Operation

- State:
  - `win_open` (1 bit).
  - `ref_val` (`width` bits).
  - `fire` register (3 bits).
- Window FSM has two states, CLOSED and OPEN. Reset state is CLOSED.
- CLOSED:
  - At a rising edge with `start_event`=1, go to OPEN and load `ref_val` with `test_expr`.
  - `end_event` is ignored in CLOSED, including when it arrives in the same cycle as `start_event`; the window still opens.
- OPEN:
  - Every rising edge compares `test_expr` with `ref_val`, including the edge on which `end_event`=1.
  - `start_event` is ignored in OPEN and does not reload `ref_val`.
  - `end_event`=1 at an edge performs the final compare, then goes to CLOSED.
- Violation: in OPEN with `test_expr` != `ref_val` and `enable`=1, `fire[0]` is 1 for the next cycle.
  - `ref_val` then reloads with the new value, so one change reports once.
  - The window stays open.
- FSM and `ref_val` update regardless of `enable`; `enable` gates only the `fire` bits.
- Comparison is full-width bitwise equality. No arithmetic.
- Changes of `test_expr` while CLOSED are never reported, including the cycle right after the `end_event` edge.

## Timing

- Reset: `win_open`=0, `ref_val`=0, `fire`=3'b000, all asynchronously.
- Reset release: first active edge is the first clock rise with `reset`=0.
- Latency: `fire` bits are registered.
  - Asserted from the edge that samples the condition.
  - Held exactly one cycle.
  - Cleared at the next edge unless the condition recurs.
- A continuously changing `test_expr` in OPEN yields `fire[0]` high on consecutive cycles.
- Reset mid-window closes the window, discards `ref_val` and clears `fire` with no report.
- A new window can open at the edge immediately after the closing edge.

## Configuration

- Macro: `OVL_WIN_UNCHANGE_COVER_EN`.
- Defined: `fire[2]` pulses one cycle for each CLOSED->OPEN transition while `enable`=1.
- Undefined: coverage logic is removed and `fire[2]` is tied 0.
- `fire[0]` and `fire[1]` behaviour is identical in both builds.

## Test plan

- **Reset:** hold `reset`=1 for 2 cycles while toggling all inputs -> `fire`=000 throughout.
- **Stable window:** `width`=4, `test_expr`=4'b0100; `start_event` pulse 1 cycle; `end_event` high 2 cycles 2 cycles later; then `test_expr`=4'b1111 -> `fire[0]` never 1.
- **Violation:** `test_expr`=4'b0100; open the window; 2 cycles later `test_expr`=4'b0110 -> `fire[0]`=1 for exactly one cycle; window stays open; close later with no further fire.
- **Change on end edge:**
  - `test_expr` changes to 4'b1000 at the edge that samples `end_event`=1 -> `fire[0]` pulses.
  - The same change one cycle after the `end_event` edge -> no fire.
- **Enable gating:** `enable`=0 during a window with a change -> `fire`=000; assert `enable`=1 later in the same window with a stable value -> no fire.
- **Coverage (macro defined):** `start_event` and `end_event` high in the same cycle while CLOSED -> window opens, `fire[2]` pulses once; a later change is flagged on `fire[0]`.
